// File: rtl/s27_pkg.sv
// s27_pkg: shared state type and next-state function for the s27 channel FSM.
package s27_pkg;
  localparam int STATE_W = 3;
  typedef struct packed {
    logic s0;
    logic s1;
    logic s2;
  } s27_state_t;
  typedef struct packed {
    s27_state_t state;
    logic n16;
  } s27_next_t;
  function automatic s27_next_t s27_next(input s27_state_t s, input logic g0, g1, g2, g3);
    logic a, n16;
    a = s.s1 & ~g0;
    n16 = ~((g1 | s.s0) & ~a) & ~(~a & ~g3) & ~s.s2;
    return '{state: '{s0: ~g2 & (g1 | s.s0), s1: n16, s2: g0 & ~n16}, n16: n16};
  endfunction
endpackage

// File: rtl/s27_core.sv
// s27_core: one s27 channel with enable, saturating G17-toggle counter and,
// when S27_SCAN_EN is defined, a scan shift path through its three state flops.
module s27_core
  import s27_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic clk_net,
  input  logic reset_net,
  input  logic en,
  input  logic g0,
  input  logic g1,
  input  logic g2,
  input  logic g3,
  input  logic cnt_clr,
`ifdef S27_SCAN_EN
  input  logic scan_en,
  input  logic scan_in,
  output logic scan_out,
`endif
  output logic g17,
  output logic [STATE_W-1:0] state,
  output logic [CNT_W-1:0] cnt
);
  s27_state_t st;
  s27_next_t nx;
  logic g17_prev, cnt_hold;
  assign nx = s27_next(st, g0, g1, g2, g3);
  assign g17 = ~nx.n16;
  assign state = {st.s2, st.s1, st.s0};
`ifdef S27_SCAN_EN
  assign scan_out = st.s2;
  assign cnt_hold = scan_en;
`else
  assign cnt_hold = 1'b0;
`endif
  // g17_prev tracks every cycle so a change seen while disabled is not counted later
  always_ff @(posedge clk_net) begin
    if (!reset_net) begin
      st <= '0;
      g17_prev <= 1'b1;
      cnt <= '0;
    end else begin
      g17_prev <= g17;
`ifdef S27_SCAN_EN
      if (scan_en) st <= '{s0: scan_in, s1: st.s0, s2: st.s1};
      else if (en) st <= nx.state;
`else
      if (en) st <= nx.state;
`endif
      if (cnt_clr) cnt <= '0;
      else if (en && !cnt_hold && g17 != g17_prev && cnt != '1) cnt <= cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/s27_array.sv
// s27_array: N_CH independent s27 channels with optional registered G17;
// defining S27_SCAN_EN adds one scan chain ch0.S0 -> ... -> ch(N_CH-1).S2.
module s27_array
  import s27_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int CNT_W = 8,
  parameter int PIPE_OUT = 1
) (
  input  logic clk_net,
  input  logic reset_net,
  input  logic [N_CH-1:0] en,
  input  logic [N_CH-1:0] G0,
  input  logic [N_CH-1:0] G1,
  input  logic [N_CH-1:0] G2,
  input  logic [N_CH-1:0] G3,
  input  logic cnt_clr,
`ifdef S27_SCAN_EN
  input  logic scan_en,
  input  logic scan_in,
  output logic scan_out,
`endif
  output logic [N_CH-1:0] G17,
  output logic [STATE_W*N_CH-1:0] state_q,
  output logic [CNT_W*N_CH-1:0] toggle_cnt
);
  logic [N_CH-1:0] g17_c;
`ifdef S27_SCAN_EN
  logic [N_CH:0] chain;
  assign chain[0] = scan_in;
  assign scan_out = chain[N_CH];
`endif
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    s27_core #(.CNT_W(CNT_W)) u_core (
      .clk_net(clk_net),
      .reset_net(reset_net),
      .en(en[c]),
      .g0(G0[c]),
      .g1(G1[c]),
      .g2(G2[c]),
      .g3(G3[c]),
      .cnt_clr(cnt_clr),
`ifdef S27_SCAN_EN
      .scan_en(scan_en),
      .scan_in(chain[c]),
      .scan_out(chain[c+1]),
`endif
      .g17(g17_c[c]),
      .state(state_q[STATE_W*c +: STATE_W]),
      .cnt(toggle_cnt[CNT_W*c +: CNT_W])
    );
  end
  // reset value 1 equals the combinational G17 of state 000 with all inputs 0
  if (PIPE_OUT != 0) begin : g_pipe
    always_ff @(posedge clk_net) G17 <= !reset_net ? '1 : g17_c;
  end else begin : g_comb
    assign G17 = g17_c;
  end
endmodule

// File: tb/tb_s27_array.sv
// tb_s27_array: directed vector table for s27_array, a registered-output/8-bit
// instance and a combinational-output/2-bit-counter instance sharing stimulus.
module tb_s27_array;
  logic clk_net = 1'b0;
  logic reset_net;
  logic [3:0] en, G0, G1, G2, G3;
  logic cnt_clr;
  logic [3:0] g17_a, g17_b;
  logic [11:0] state_a, state_b;
  logic [31:0] cnt_a;
  logic [7:0] cnt_b;
`ifdef S27_SCAN_EN
  logic scan_en, scan_in, scan_out_a, scan_out_b;
`endif
  int pass_n = 0;
  int total_n = 0;

  always #5 clk_net = ~clk_net;

  s27_array dut (
    .clk_net(clk_net), .reset_net(reset_net), .en(en),
    .G0(G0), .G1(G1), .G2(G2), .G3(G3), .cnt_clr(cnt_clr),
`ifdef S27_SCAN_EN
    .scan_en(scan_en), .scan_in(scan_in), .scan_out(scan_out_a),
`endif
    .G17(g17_a), .state_q(state_a), .toggle_cnt(cnt_a)
  );

  s27_array #(.N_CH(4), .CNT_W(2), .PIPE_OUT(0)) dut2 (
    .clk_net(clk_net), .reset_net(reset_net), .en(en),
    .G0(G0), .G1(G1), .G2(G2), .G3(G3), .cnt_clr(cnt_clr),
`ifdef S27_SCAN_EN
    .scan_en(scan_en), .scan_in(scan_in), .scan_out(scan_out_b),
`endif
    .G17(g17_b), .state_q(state_b), .toggle_cnt(cnt_b)
  );

  // c0/c1 are {G0,G1,G2,G3} for channels 0 and 1; channels 2 and 3 stay 0
  typedef struct {
    logic [3:0] en;
    logic [3:0] c0;
    logic [3:0] c1;
    logic clr;
    logic [3:0] g17;
    logic [11:0] st;
    logic [7:0] n0;
    logic [1:0] n0s;
  } vec_t;
  vec_t v[$];

  function automatic vec_t mk(logic [3:0] e, logic [3:0] c0, logic [3:0] c1, logic clr,
                              logic [3:0] g, logic [11:0] s, logic [7:0] n0, logic [1:0] n0s);
    vec_t x;
    x.en = e; x.c0 = c0; x.c1 = c1; x.clr = clr;
    x.g17 = g; x.st = s; x.n0 = n0; x.n0s = n0s;
    return x;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(logic [3:0] e, logic [3:0] c0, logic [3:0] c1, logic clr);
    en = e;
    cnt_clr = clr;
    G0 = {2'b00, c1[3], c0[3]};
    G1 = {2'b00, c1[2], c0[2]};
    G2 = {2'b00, c1[1], c0[1]};
    G3 = {2'b00, c1[0], c0[0]};
  endtask

  initial begin
    logic [11:0] pat;
    reset_net = 1'b0;
    drive(4'hF, 4'h0, 4'h0, 1'b0);
`ifdef S27_SCAN_EN
    scan_en = 1'b0;
    scan_in = 1'b0;
`endif
    repeat (2) @(posedge clk_net);
    #1;
    check("rst state_a", 32'(state_a), 32'h0);
    check("rst state_b", 32'(state_b), 32'h0);
    check("rst g17_a", 32'(g17_a), 32'hF);
    check("rst g17_b", 32'(g17_b), 32'hF);
    check("rst cnt_a", cnt_a, 32'h0);
    @(negedge clk_net) reset_net = 1'b1;

    v.push_back(mk(4'hF, 4'h0, 4'h0, 0, 4'hF, 12'h000, 0, 0));
    v.push_back(mk(4'hF, 4'h1, 4'h0, 0, 4'hE, 12'h002, 1, 1));
    v.push_back(mk(4'hF, 4'h0, 4'h0, 0, 4'hE, 12'h002, 1, 1));
    v.push_back(mk(4'hF, 4'h8, 4'h0, 0, 4'hF, 12'h004, 2, 2));
    v.push_back(mk(4'hF, 4'h0, 4'h0, 0, 4'hF, 12'h000, 2, 2));
    v.push_back(mk(4'hD, 4'h0, 4'h4, 0, 4'hF, 12'h000, 2, 2));
    v.push_back(mk(4'hD, 4'h0, 4'h4, 0, 4'hF, 12'h000, 2, 2));
    v.push_back(mk(4'hD, 4'h0, 4'h4, 0, 4'hF, 12'h000, 2, 2));
    v.push_back(mk(4'hF, 4'h0, 4'h4, 0, 4'hF, 12'h008, 2, 2));
    v.push_back(mk(4'hF, 4'h0, 4'h0, 0, 4'hF, 12'h008, 2, 2));
    v.push_back(mk(4'hE, 4'h1, 4'h0, 0, 4'hE, 12'h008, 2, 2));
    v.push_back(mk(4'hF, 4'h0, 4'h0, 0, 4'hF, 12'h008, 3, 3));
    v.push_back(mk(4'hF, 4'h1, 4'h0, 0, 4'hE, 12'h00A, 4, 3));
    v.push_back(mk(4'hF, 4'h8, 4'h0, 0, 4'hF, 12'h00C, 5, 3));
    v.push_back(mk(4'hF, 4'h0, 4'h0, 0, 4'hF, 12'h008, 5, 3));
    v.push_back(mk(4'hF, 4'h1, 4'h0, 0, 4'hE, 12'h00A, 6, 3));
    v.push_back(mk(4'hF, 4'h8, 4'h0, 0, 4'hF, 12'h00C, 7, 3));
    v.push_back(mk(4'hF, 4'h0, 4'h0, 0, 4'hF, 12'h008, 7, 3));
    v.push_back(mk(4'hF, 4'h1, 4'h0, 0, 4'hE, 12'h00A, 8, 3));
    v.push_back(mk(4'hF, 4'h8, 4'h0, 0, 4'hF, 12'h00C, 9, 3));
    v.push_back(mk(4'hF, 4'h0, 4'h0, 0, 4'hF, 12'h008, 9, 3));
    v.push_back(mk(4'hF, 4'h1, 4'h0, 1, 4'hE, 12'h00A, 0, 0));
    v.push_back(mk(4'hF, 4'h0, 4'h0, 0, 4'hE, 12'h00A, 0, 0));
    v.push_back(mk(4'hF, 4'h8, 4'h0, 0, 4'hF, 12'h00C, 1, 1));

    for (int i = 0; i < v.size(); i++) begin
      @(negedge clk_net);
      drive(v[i].en, v[i].c0, v[i].c1, v[i].clr);
      #1 check($sformatf("v%0d g17_comb", i), 32'(g17_b), 32'(v[i].g17));
      @(posedge clk_net);
      #1;
      check($sformatf("v%0d state_a", i), 32'(state_a), 32'(v[i].st));
      check($sformatf("v%0d state_b", i), 32'(state_b), 32'(v[i].st));
      check($sformatf("v%0d g17_reg", i), 32'(g17_a), 32'(v[i].g17));
      check($sformatf("v%0d cnt0_a", i), 32'(cnt_a[7:0]), 32'(v[i].n0));
      check($sformatf("v%0d cnt0_b", i), 32'(cnt_b[1:0]), 32'(v[i].n0s));
      check($sformatf("v%0d cnt_rest_a", i), 32'(cnt_a[31:8]), 32'h0);
      check($sformatf("v%0d cnt_rest_b", i), 32'(cnt_b[7:2]), 32'h0);
    end

    // reset mid-operation while comb G17 of ch0 is 0 and a toggle is pending
    @(negedge clk_net);
    drive(4'hF, 4'h0, 4'h0, 1'b0);
    @(negedge clk_net);
    drive(4'hF, 4'h1, 4'h0, 1'b0);
    reset_net = 1'b0;
    #1 check("pre-rst g17_comb", 32'(g17_b), 32'hE);
    @(posedge clk_net);
    #1;
    check("mid-rst state_a", 32'(state_a), 32'h0);
    check("mid-rst g17_reg", 32'(g17_a), 32'hF);
    check("mid-rst cnt_a", cnt_a, 32'h0);
    check("mid-rst cnt_b", 32'(cnt_b), 32'h0);
    @(negedge clk_net);
    drive(4'hF, 4'h0, 4'h0, 1'b0);
    reset_net = 1'b1;
    @(posedge clk_net);
    #1;
    check("post-rst state_a", 32'(state_a), 32'h0);
    check("post-rst g17_reg", 32'(g17_a), 32'hF);

`ifdef S27_SCAN_EN
    pat = 12'hB2C;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk_net);
      drive(4'hF, 4'h1, 4'h0, 1'b0);
      scan_en = 1'b1;
      scan_in = pat[11-k];
      #1 check($sformatf("scan%0d out", k), 32'(scan_out_a), 32'h0);
    end
    @(posedge clk_net);
    #1;
    check("scan state_a", 32'(state_a), 32'(pat));
    check("scan state_b", 32'(state_b), 32'(pat));
    check("scan cnt_a", cnt_a, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_net);
      scan_in = 1'b0;
      #1 check($sformatf("unload%0d out_a", k), 32'(scan_out_a), 32'(pat[11-k]));
      check($sformatf("unload%0d out_b", k), 32'(scan_out_b), 32'(pat[11-k]));
    end
    @(negedge clk_net);
    reset_net = 1'b0;
    scan_in = 1'b1;
    @(posedge clk_net);
    #1;
    check("scan-rst state_a", 32'(state_a), 32'h0);
    @(negedge clk_net);
    reset_net = 1'b1;
    scan_en = 1'b0;
    scan_in = 1'b0;
`else
    pat = 12'h0;
    check("idle state_a", 32'(state_a), 32'(pat));
`endif

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
